port_timer: RTL

- Port-mapped 16-bit down-counting timer with 8-bit prescaler and interrupt generation for the pacoblaze3 system.
- Sits on the processor I/O bus (port_id / out_port / write_strobe / read_strobe) alongside the existing output and input ports.
- Acts as the upstream interrupt source: its irq output drives the core's interrupt input.
- Read data is OR-combined with the other input devices into in_port.

---
 rtl/port_timer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/port_timer.sv
// Port-mapped 16-bit down-counting timer with 8-bit prescaler and level interrupt.
// Occupies ADDR..ADDR+6 on the pacoblaze3 I/O bus; read data is registered and zero outside the window.
module port_timer #(
  parameter logic [7:0] ADDR = 8'h10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] address,
  input  logic [7:0] value_in,
  input  logic       wen,
  input  logic       ren,
  input  logic       interrupt_ack,
  output logic [7:0] value_out,
  output logic       irq
);

  typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} state_e;

  localparam logic [7:0] OFF_CTRL   = 8'd0;
  localparam logic [7:0] OFF_REL_LO = 8'd1;
  localparam logic [7:0] OFF_REL_HI = 8'd2;
  localparam logic [7:0] OFF_PRESC  = 8'd3;
  localparam logic [7:0] OFF_STATUS = 8'd4;
  localparam logic [7:0] OFF_CNT_LO = 8'd5;
  localparam logic [7:0] OFF_CNT_HI = 8'd6;

  state_e      state_q, state_d;
  logic        periodic_q, periodic_d;
  logic        ie_q, ie_d;
  logic        tf_q, tf_d;
  logic        irq_q, irq_d;
  logic [15:0] reload_q, reload_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  presc_q, presc_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  shadow_q, shadow_d;
  logic [7:0]  value_out_q, value_out_d;

  logic [7:0]  offset;
  logic        in_win;
  logic        wr_ctrl, wr_status;
  logic        expire;

  // Modular subtraction keeps the window check correct even if ADDR+6 wraps.
  assign offset    = address - ADDR;
  assign in_win    = offset < 8'd7;
  assign wr_ctrl   = wen && (offset == OFF_CTRL);
  assign wr_status = wen && (offset == OFF_STATUS);

  always_comb begin
    state_d    = state_q;
    periodic_d = periodic_q;
    ie_d       = ie_q;
    count_d    = count_q;
    pc_d       = pc_q;
    expire     = 1'b0;

    if (state_q == RUNNING) begin
      if (pc_q == presc_q) begin
        pc_d = 8'd0;
        if (count_q == 16'd0) begin
          expire = 1'b1;
          if (periodic_q) count_d = reload_q;
          else            state_d = STOPPED;
        end else begin
          count_d = count_q - 16'd1;
        end
      end else begin
        pc_d = pc_q + 8'd1;
      end
    end

    // A stop write freezes count/pc, but an expiry on the same edge still raises TF.
    if (wr_ctrl) begin
      periodic_d = value_in[1];
      ie_d       = value_in[2];
      if (!value_in[0]) begin
        state_d = STOPPED;
        count_d = count_q;
        pc_d    = pc_q;
      end else if (state_q == STOPPED) begin
        state_d = RUNNING;
        count_d = reload_q;
        pc_d    = 8'd0;
      end
    end
  end

  always_comb begin
    reload_d = reload_q;
    presc_d  = presc_q;
    if (wen && (offset == OFF_REL_LO)) reload_d[7:0]  = value_in;
    if (wen && (offset == OFF_REL_HI)) reload_d[15:8] = value_in;
    if (wen && (offset == OFF_PRESC))  presc_d        = value_in;
  end

  always_comb begin
    tf_d = tf_q;
    if (expire)                                      tf_d = 1'b1;
    else if ((wr_status && value_in[0]) || interrupt_ack) tf_d = 1'b0;
    irq_d = tf_d & ie_d;
  end

  always_comb begin
    shadow_d = shadow_q;
    if (ren && (offset == OFF_CNT_LO)) shadow_d = count_q[15:8];
  end

  always_comb begin
    value_out_d = 8'h00;
    if (in_win) begin
      case (offset)
        OFF_CTRL:   value_out_d = {5'b0, ie_q, periodic_q, state_q == RUNNING};
        OFF_REL_LO: value_out_d = reload_q[7:0];
        OFF_REL_HI: value_out_d = reload_q[15:8];
        OFF_PRESC:  value_out_d = presc_q;
        OFF_STATUS: value_out_d = {7'b0, tf_q};
        OFF_CNT_LO: value_out_d = count_q[7:0];
        OFF_CNT_HI: value_out_d = shadow_q;
        default:    value_out_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= STOPPED;
      periodic_q  <= 1'b0;
      ie_q        <= 1'b0;
      tf_q        <= 1'b0;
      irq_q       <= 1'b0;
      reload_q    <= 16'h0000;
      count_q     <= 16'h0000;
      presc_q     <= 8'h00;
      pc_q        <= 8'h00;
      shadow_q    <= 8'h00;
      value_out_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      periodic_q  <= periodic_d;
      ie_q        <= ie_d;
      tf_q        <= tf_d;
      irq_q       <= irq_d;
      reload_q    <= reload_d;
      count_q     <= count_d;
      presc_q     <= presc_d;
      pc_q        <= pc_d;
      shadow_q    <= shadow_d;
      value_out_q <= value_out_d;
    end
  end

  assign value_out = value_out_q;
  assign irq       = irq_q;

endmodule
